slon_rx_checker: RTL and testbench



---
 rtl/slon_rx_checker.sv | 174 +++++++++++++++++
 tb/tb_slon_rx_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/slon_rx_checker.sv
// Receiver/checker for the slon output stage: samples din at each synchronised in_clk fall,
// checks the +1 sequence, tracks lock and keeps saturating statistics. Optional idle timeout: SLON_RX_TIMEOUT_EN.
module slon_rx_checker #(
  parameter int DATA_WIDTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_COUNT     = 4,
  parameter int UNLOCK_ERRORS  = 3,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_clk,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear_stats,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  locked,
  output logic                  err_pulse,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  timeout
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRORS + 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED_ST} state_t;

  state_t                 state, state_next;
  logic [GW-1:0]          good_cnt, good_next, good_inc;
  logic [BW-1:0]          bad_cnt, bad_next, bad_inc;
  logic                   err_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   fall;
  logic                   seq_ok;
  logic [DATA_WIDTH-1:0]  expected_word;
  logic [CNT_WIDTH-1:0]   word_count_next, err_count_next;
  logic                   timeout_hit;

  assign fall          = sync_prev & ~sync[SYNC_STAGES-1];
  assign expected_word = word_out + DATA_WIDTH'(1);
  assign seq_ok        = (din == expected_word);
  assign good_inc      = good_cnt + GW'(1);
  assign bad_inc       = bad_cnt + BW'(1);
  assign locked        = (state == LOCKED_ST);

  // Synchroniser plus the previous-value register used for fall detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], in_clk};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

`ifdef SLON_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt;
  logic          timeout_reg;

  assign timeout_hit = (idle_cnt == IW'(TIMEOUT_CYCLES)) && !fall;
  assign timeout     = timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      if (fall)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + IW'(1);
      if (clear_stats)
        timeout_reg <= 1'b0;
      else if (timeout_hit)
        timeout_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    err_next   = 1'b0;
    if (fall) begin
      case (state)
        HUNT: begin
          good_next  = GW'(1);
          state_next = ACQUIRE;
        end
        ACQUIRE: begin
          if (seq_ok) begin
            good_next = good_inc;
            if (good_inc == GW'(LOCK_COUNT)) begin
              state_next = LOCKED_ST;
              bad_next   = '0;
            end
          end else begin
            good_next = GW'(1);
          end
        end
        LOCKED_ST: begin
          if (seq_ok) begin
            bad_next = '0;
          end else begin
            err_next = 1'b1;
            bad_next = bad_inc;
            if (bad_inc == BW'(UNLOCK_ERRORS))
              state_next = HUNT;
          end
        end
        default: state_next = HUNT;
      endcase
    end
    if (timeout_hit)
      state_next = HUNT;
  end

  // Clear beats a same-cycle capture; both counters stick at all-ones
  always_comb begin
    word_count_next = word_count;
    err_count_next  = err_count;
    if (clear_stats) begin
      word_count_next = '0;
      err_count_next  = '0;
    end else begin
      if (fall && !(&word_count))
        word_count_next = word_count + CNT_WIDTH'(1);
      if (err_next && !(&err_count))
        err_count_next = err_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      good_cnt   <= '0;
      bad_cnt    <= '0;
      word_valid <= 1'b0;
      word_out   <= '0;
      err_pulse  <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_next;
      good_cnt   <= good_next;
      bad_cnt    <= bad_next;
      word_valid <= fall;
      err_pulse  <= err_next;
      word_count <= word_count_next;
      err_count  <= err_count_next;
      if (fall)
        word_out <= din;
    end
  end

endmodule

// File: tb/tb_slon_rx_checker.sv
// Bench for slon_rx_checker: directed word stream, scoreboard of expected capture results,
// checked by a monitor whenever word_valid pulses.
module tb_slon_rx_checker;

  localparam int DW     = 8;
  localparam int SYNC   = 2;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;
  localparam int CW     = 16;
  localparam int TMO    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_clk;
  logic [DW-1:0] din;
  logic          clear_stats;
  logic          word_valid;
  logic [DW-1:0] word_out;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] word_count;
  logic [CW-1:0] err_count;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] w;
    logic          err;
    logic          lk;
    logic [CW-1:0] wc;
    logic [CW-1:0] ec;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int            m_state = 0;  // 0 hunt, 1 acquire, 2 locked
  int            m_good  = 0;
  int            m_bad   = 0;
  logic [DW-1:0] m_ref   = '0;
  int            m_wc    = 0;
  int            m_ec    = 0;

  slon_rx_checker #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCK),
    .UNLOCK_ERRORS(UNLOCK), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .in_clk(in_clk), .din(din), .clear_stats(clear_stats),
    .word_valid(word_valid), .word_out(word_out), .locked(locked), .err_pulse(err_pulse),
    .word_count(word_count), .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_wc = 0; m_ec = 0;
  endtask

  // Predict the result of one capture and push it, then drive one in_clk period (8 clk)
  task automatic send_word(input logic [DW-1:0] w, input bit clr);
    exp_t e;
    logic [DW-1:0] nxt;
    nxt   = m_ref + 8'd1;
    e.err = 1'b0;
    case (m_state)
      0: begin m_good = 1; m_state = 1; end
      1: begin
        if (w == nxt) begin
          m_good++;
          if (m_good == LOCK) begin m_state = 2; m_bad = 0; end
        end else m_good = 1;
      end
      default: begin
        if (w == nxt) m_bad = 0;
        else begin
          e.err = 1'b1;
          if (m_ec < 65535) m_ec++;
          m_bad++;
          if (m_bad == UNLOCK) m_state = 0;
        end
      end
    endcase
    m_ref = w;
    if (m_wc < 65535) m_wc++;
    if (clr) begin m_wc = 0; m_ec = 0; end
    e.w  = w;
    e.lk = (m_state == 2);
    e.wc = CW'(m_wc);
    e.ec = CW'(m_ec);
    sb.push_back(e);

    in_clk = 1'b1;
    din    = w;
    repeat (4) @(negedge clk);
    in_clk = 1'b0;
    repeat (SYNC - 1) @(negedge clk);
    @(negedge clk);
    if (clr) clear_stats = 1'b1;
    check("valid_early", 32'(word_valid), 32'd0);
    @(negedge clk);
    clear_stats = 1'b0;
    check("valid_latency", 32'(word_valid), 32'd1);
    @(negedge clk);
  endtask

  // Monitor: pop and compare one scoreboard entry per captured word
  always @(negedge clk) begin
    if (word_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("word %02h err=%0d locked=%0d word_count=%0d err_count=%0d",
                 word_out, err_pulse, locked, word_count, err_count);
        check("word_out", 32'(word_out), 32'(e.w));
        check("err_pulse", 32'(err_pulse), 32'(e.err));
        check("locked", 32'(locked), 32'(e.lk));
        check("word_count", 32'(word_count), 32'(e.wc));
        check("err_count", 32'(err_count), 32'(e.ec));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_word"}, 32'(word_out), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(err_pulse), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_ec"}, 32'(err_count), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_clk = 1'b0; din = '0; clear_stats = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Counting run: locks after the 4th word
    for (int i = 0; i <= 'h11; i++) send_word(8'(i), 1'b0);
    // Single corrupted word costs two errors, lock held
    send_word(8'h55, 1'b0);
    send_word(8'h13, 1'b0);
    send_word(8'h14, 1'b0);
    // Three consecutive bad words drop lock
    send_word(8'h80, 1'b0);
    send_word(8'h90, 1'b0);
    send_word(8'hA0, 1'b0);
    // Relock, then wrap through 0xFF -> 0x00
    for (int i = 'hFA; i <= 'h101; i++) send_word(8'(i), 1'b0);
    // clear_stats coincident with a capture
    send_word(8'h02, 1'b1);
    send_word(8'h03, 1'b0);

    // Idle in_clk
    repeat (70) @(negedge clk);
`ifdef SLON_RX_TIMEOUT_EN
    check("idle_timeout", 32'(timeout), 32'd1);
    check("idle_locked", 32'(locked), 32'd0);
    m_state = 0;
`else
    check("idle_timeout", 32'(timeout), 32'd0);
    check("idle_locked", 32'(locked), 32'(m_state == 2));
`endif

    // Reset asserted mid-word, between clock edges
    in_clk = 1'b1; din = 8'h77;
    repeat (4) @(negedge clk);
    in_clk = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("discarded_capture", 32'(word_valid), 32'd0);
    end

    // Fresh stream after reset: first word only sets the reference
    for (int i = 'h40; i <= 'h45; i++) send_word(8'(i), 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
